data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit_if.sv | 34 +++
 rtl/data_mem_unit.sv | 138 +++++++++++++
 tb/tb_data_mem_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// ============================================================================
// Module : data_mem_unit_if
// Purpose: MEM-stage bus between the pipeline and the data memory unit.
//          The pipeline (master) presents load/store requests; the memory
//          unit (slave) returns load data, a pipeline stall and an error pulse.
// Signals: MEMMemRd, MEMMemWr, MEMByte, ALUOutM[15:0], DataInM[15:0]
//          (master -> slave); DataOut[15:0], mem_stall, mem_err
//          (slave -> master).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_unit_if;
  logic        MEMMemRd;
  logic        MEMMemWr;
  logic        MEMByte;
  logic [15:0] ALUOutM;
  logic [15:0] DataInM;
  logic [15:0] DataOut;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output MEMMemRd, MEMMemWr, MEMByte, ALUOutM, DataInM,
    input  DataOut, mem_stall, mem_err
  );

  modport slave (
    input  MEMMemRd, MEMMemWr, MEMByte, ALUOutM, DataInM,
    output DataOut, mem_stall, mem_err
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_unit.sv
// ============================================================================
// Module : data_mem_unit
// Purpose: Multi-cycle 16-bit data memory for the MEM stage. Each access
//          stalls the pipeline for LATENCY cycles, then completes in a
//          one-cycle DONE state where the pipeline advances. Supports word
//          and byte loads/stores; illegal accesses finish immediately with
//          a one-cycle error pulse.
// Ports  : clk      - rising-edge clock
//          reset    - asynchronous, active-low reset
//          mem_bus  - data_mem_unit_if.slave (requests in, data/stall/err out)
// Params : ADDR_W   - log2 of the number of 16-bit words
//          LATENCY  - stall cycles per legal access (1..15)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_unit #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_unit_if.slave mem_bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] c_LOAD   = 4'(LATENCY - 1);
  localparam bit         c_SINGLE = (LATENCY == 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_dout;
  logic        r_err;
  logic [15:0] r_mem [DEPTH];

  logic              w_rd;
  logic              w_wr;
  logic              w_req;
  logic              w_oor;
  logic              w_misal;
  logic              w_illegal;
  logic [ADDR_W-1:0] w_idx;
  logic [15:0]       w_word;
  logic [7:0]        w_lane;
  logic [15:0]       w_rdata;
  logic [15:0]       w_merge;
  logic              w_last_wait;
  logic              w_leave;
  logic              w_err_go;
  logic              w_write;
  logic              w_read;

  assign w_rd      = mem_bus.MEMMemRd;
  assign w_wr      = mem_bus.MEMMemWr;
  assign w_req     = w_rd | w_wr;
  // Any set address bit above the word index lies outside the array.
  assign w_oor     = (mem_bus.ALUOutM >> (ADDR_W + 1)) != 16'd0;
  assign w_misal   = ~mem_bus.MEMByte & mem_bus.ALUOutM[0];
  assign w_illegal = (w_rd & w_wr) | w_oor | w_misal;

  assign w_idx   = mem_bus.ALUOutM[ADDR_W:1];
  assign w_word  = r_mem[w_idx];
  assign w_lane  = mem_bus.ALUOutM[0] ? w_word[15:8] : w_word[7:0];
  assign w_rdata = mem_bus.MEMByte ? {8'h00, w_lane} : w_word;
  assign w_merge = !mem_bus.MEMByte     ? mem_bus.DataInM :
                   mem_bus.ALUOutM[0]   ? {mem_bus.DataInM[7:0], w_word[7:0]} :
                                          {w_word[15:8], mem_bus.DataInM[7:0]};

  // BUSY holds LATENCY-1 cycles: the count runs LATENCY-1 down to 1 and the
  // edge that takes it to zero is also the edge into DONE, so a request seen
  // in cycle T reaches DONE in T+LATENCY.
  assign w_last_wait = (r_state == S_BUSY) && (r_cnt <= 4'd1);

  // The access is performed on the edge that leaves the wait phase, using
  // the operands presented in that cycle.
  assign w_leave  = w_req && !w_illegal &&
                    (((r_state == S_IDLE) && c_SINGLE) || w_last_wait);
  assign w_err_go = (r_state == S_IDLE) && w_req && w_illegal;
  assign w_write  = w_leave && w_wr;
  assign w_read   = w_leave && w_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dout  <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err_go;

      // Storage is never cleared; writes are simply blocked while in reset.
      if (w_write) begin
        r_mem[w_idx] <= w_merge;
      end

      if (w_read) begin
        r_dout <= w_rdata;
      end else if (w_err_go && w_rd) begin
        r_dout <= 16'h0000;
      end

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_illegal || c_SINGLE) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= c_LOAD;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last_wait) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational so the pipeline freezes in the request cycle;
  // reset forces it low immediately.
  assign mem_bus.mem_stall = reset &
                             (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));
  assign mem_bus.DataOut   = r_dout;
  assign mem_bus.mem_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// ============================================================================
// Module : tb_data_mem_unit
// Purpose: Self-checking bench for data_mem_unit. Instance A uses LATENCY=2,
//          instance B uses LATENCY=1. Directed vector table, hand-written
//          reset and back-to-back sequences, and random accesses checked
//          against an array-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_unit;

  localparam int AW    = 8;
  localparam int MEMW  = 1 << AW;
  localparam int LAT_A = 2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        byt;
    logic [15:0] addr;
    logic [15:0] din;
    int          st;
    logic        er;
    logic [15:0] dout;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [15:0] m_mem [MEMW];
  logic [15:0] m_dout;

  data_mem_unit_if ifa ();
  data_mem_unit_if ifb ();

  data_mem_unit #(.ADDR_W(AW), .LATENCY(LAT_A)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .mem_bus (ifa)
  );

  data_mem_unit #(.ADDR_W(AW), .LATENCY(1)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .mem_bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic byt,
                              input logic [15:0] addr, input logic [15:0] din,
                              input int st, input logic er, input logic [15:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.byt = byt; v.addr = addr; v.din = din;
    v.st = st; v.er = er; v.dout = dout;
    return v;
  endfunction

  function automatic logic get_stall(input bit sb);
    return sb ? ifb.mem_stall : ifa.mem_stall;
  endfunction

  function automatic logic get_err(input bit sb);
    return sb ? ifb.mem_err : ifa.mem_err;
  endfunction

  function automatic logic [15:0] get_dout(input bit sb);
    return sb ? ifb.DataOut : ifa.DataOut;
  endfunction

  task automatic drive(input bit sb, input logic rd, input logic wr, input logic byt,
                       input logic [15:0] addr, input logic [15:0] din);
    if (sb) begin
      ifb.MEMMemRd = rd; ifb.MEMMemWr = wr; ifb.MEMByte = byt;
      ifb.ALUOutM = addr; ifb.DataInM = din;
    end else begin
      ifa.MEMMemRd = rd; ifa.MEMMemWr = wr; ifa.MEMByte = byt;
      ifa.ALUOutM = addr; ifa.DataInM = din;
    end
  endtask

  // Counts stalled cycles from the current one, samples the DONE cycle, then
  // drops the request and samples the following cycle.
  task automatic finish_acc(input bit sb, output int st, output logic er,
                            output logic [15:0] dout, output logic er_after);
    st = 0;
    while (get_stall(sb) && st < 40) begin
      st++;
      @(negedge clk); #1;
    end
    er   = get_err(sb);
    dout = get_dout(sb);
    drive(sb, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk); #1;
    er_after = get_err(sb);
  endtask

  task automatic access(input bit sb, input logic rd, input logic wr, input logic byt,
                        input logic [15:0] addr, input logic [15:0] din,
                        output int st, output logic er, output logic [15:0] dout,
                        output logic er_after);
    drive(sb, rd, wr, byt, addr, din);
    #1;
    finish_acc(sb, st, er, dout, er_after);
  endtask

  // Reference model for instance A: legality, timing and data from the
  // access rules on a plain word array.
  task automatic model_acc(input logic rd, input logic wr, input logic byt,
                           input logic [15:0] addr, input logic [15:0] din,
                           output int st, output logic er, output logic [15:0] dout);
    int a  = int'(addr);
    int w  = (a / 2) % MEMW;
    int sh = (a % 2) * 8;
    bit ill;
    ill = (rd && wr) || (a >= 2 * MEMW) || (!byt && (a % 2) == 1);
    st  = ill ? 1 : LAT_A;
    er  = ill;
    if (ill) begin
      if (rd) m_dout = 16'h0000;
    end else if (rd) begin
      m_dout = byt ? ((m_mem[w] >> sh) & 16'h00FF) : m_mem[w];
    end else if (byt) begin
      m_mem[w] = (m_mem[w] & ~(16'h00FF << sh)) | (16'(din[7:0]) << sh);
    end else begin
      m_mem[w] = din;
    end
    dout = m_dout;
  endtask

  initial begin
    vec_t        tbl [18];
    int          st, est;
    logic        er, eer, er_after;
    logic [15:0] dout, edout;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset with a request present: everything held quiet.
    ifa.MEMMemRd = 1'b1;
    ifa.ALUOutM  = 16'h0010;
    @(negedge clk); @(negedge clk); #1;
    check("reset stall", 32'(ifa.mem_stall), 32'd0);
    check("reset err",   32'(ifa.mem_err),   32'd0);
    check("reset dout",  32'(ifa.DataOut),   32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;

    //             rd    wr    byte  addr      din       st er    dout
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 2, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hBEEF);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 16'h0011, 16'h005A, 2, 1'b0, 16'hBEEF);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'h5AEF);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 2, 1'b0, 16'h00EF);
    tbl[5]  = mk(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 2, 1'b0, 16'h005A);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 16'h0004, 16'h1111, 2, 1'b0, 16'h005A);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 16'h0004, 16'h2222, 1, 1'b1, 16'h0000);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 2, 1'b0, 16'h1111);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 16'h0201, 16'h0000, 1, 1'b1, 16'h0000);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'h5AEF);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 1, 1'b1, 16'h0000);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'h5AEF);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 16'h0400, 16'hFFFF, 1, 1'b1, 16'h5AEF);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 16'h01FF, 16'hA577, 2, 1'b0, 16'h5AEF);
    tbl[15] = mk(1'b1, 1'b0, 1'b1, 16'h01FF, 16'h0000, 2, 1'b0, 16'h0077);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 16'h0013, 16'h0000, 1, 1'b1, 16'h0077);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'h5AEF);

    for (int i = 0; i < 18; i++) begin
      access(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].byt, tbl[i].addr, tbl[i].din,
             st, er, dout, er_after);
      check($sformatf("vec%0d stall cycles", i), 32'(st),       32'(tbl[i].st));
      check($sformatf("vec%0d err", i),          32'(er),       32'(tbl[i].er));
      check($sformatf("vec%0d dout", i),         32'(dout),     32'(tbl[i].dout));
      check($sformatf("vec%0d err pulse end", i), 32'(er_after), 32'd0);
    end

    // Reset in the middle of a write aborts it; a request held through
    // reset restarts as a fresh access afterwards.
    access(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'hAAAA, st, er, dout, er_after);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234);
    #1;
    check("abort stall T", 32'(ifa.mem_stall), 32'd1);
    @(negedge clk); #1;
    check("abort stall busy", 32'(ifa.mem_stall), 32'd1);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    #1;
    check("abort stall drop", 32'(ifa.mem_stall), 32'd0);
    check("abort dout clr",   32'(ifa.DataOut),   32'd0);
    @(negedge clk); #1;
    check("abort stall held", 32'(ifa.mem_stall), 32'd0);
    reset = 1'b1;
    #1;
    finish_acc(1'b0, st, er, dout, er_after);
    check("restart stall cycles", 32'(st),   32'(LAT_A));
    check("restart err",          32'(er),   32'd0);
    check("restart old data",     32'(dout), 32'h0000AAAA);

    // Fill every word so random reads compare against known contents.
    m_dout = 16'hAAAA;
    for (int i = 0; i < MEMW; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      model_acc(1'b0, 1'b1, 1'b0, 16'(2 * i), d, est, eer, edout);
      access(1'b0, 1'b0, 1'b1, 1'b0, 16'(2 * i), d, st, er, dout, er_after);
    end

    for (int n = 0; n < 300; n++) begin
      int          r;
      logic        rd, wr, byt;
      logic [15:0] addr, din;
      r    = int'($urandom_range(0, 99));
      rd   = (r < 55);
      wr   = (r < 10) || (r >= 55);
      byt  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? (16'($urandom) | 16'h0200)
                                         : 16'($urandom_range(0, 2 * MEMW - 1));
      din  = 16'($urandom);
      model_acc(rd, wr, byt, addr, din, est, eer, edout);
      access(1'b0, rd, wr, byt, addr, din, st, er, dout, er_after);
      check($sformatf("rnd%0d stall cycles", n), 32'(st),   32'(est));
      check($sformatf("rnd%0d err", n),          32'(er),   32'(eer));
      check($sformatf("rnd%0d dout", n),         32'(dout), 32'(edout));
    end

    // LATENCY=1: three back-to-back reads give stall 1,0,1,0,1,0.
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h1111, st, er, dout, er_after);
    check("b wr0 stall", 32'(st), 32'd1);
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0032, 16'h2222, st, er, dout, er_after);
    check("b wr1 stall", 32'(st), 32'd1);
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0034, 16'h3333, st, er, dout, er_after);
    check("b wr2 stall", 32'(st), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_d;
      exp_d = 16'h1111 * 16'(i + 1);
      #1;
      check($sformatf("b rd%0d stall T", i), 32'(ifb.mem_stall), 32'd1);
      @(negedge clk); #1;
      check($sformatf("b rd%0d stall done", i), 32'(ifb.mem_stall), 32'd0);
      check($sformatf("b rd%0d data", i),       32'(ifb.DataOut),   32'(exp_d));
      if (i < 2) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'(16'h0032 + 16'(2 * i)), 16'h0000);
      else       drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
